rmii_rx_framer: RTL and testbench

Receive-side PHY framer, directly upstream of the Ethernet/IP/UDP RX parser. Samples the RMII receive interface (CRS_DV, RXD[1:0], RX_ER) on the 50 MHz reference clock and locks onto preamble and SFD. Assembles dibits LSB-first into bytes and emits a byte stream marked with start/end/error flags. Its first output byte is the first destination-MAC byte, which is what the parser's ETH_HEADER state expects after its IDLE state.

---
 rtl/eth_types_pkg.sv | 23 ++
 rtl/rmii_byte_assembler.sv | 46 ++++
 rtl/rmii_rx_framer.sv | 225 ++++++++++++++++++++++
 tb/tb_rmii_rx_framer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_types_pkg
// Description : Shared types and constants for the Ethernet receive path.
//               Holds the RMII framer state encoding and the preamble/SFD
//               dibit values used when locking onto a frame.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_types_pkg;

    // RMII receive framer states; DRAIN is the reset state.
    typedef enum logic [1:0] {
        DRAIN    = 2'd0,
        IDLE     = 2'd1,
        PREAMBLE = 2'd2,
        DATA     = 2'd3
    } rmii_rx_states;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT      = 2'b11;

endpackage
`default_nettype wire

// File: rtl/rmii_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : rmii_byte_assembler
// Description : Packs RMII dibits LSB-first into bytes. Dibit k of a byte
//               lands in bits [2k+1:2k]. The completed byte and its done
//               pulse are presented combinationally on the cycle the 4th
//               dibit is shifted, so the framer can park it on that edge.
// Ports       : clk, rst_n      - clock, async active-low reset
//               clear           - synchronous restart of the dibit index
//               shift_en, dibit - accept one dibit this cycle
//               byte_data       - completed byte (valid while done=1)
//               dibit_idx       - dibits already held for the current byte
//               done            - 4th dibit of a byte accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rmii_byte_assembler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       shift_en,
    input  logic [1:0] dibit,
    output logic [7:0] byte_data,
    output logic [1:0] dibit_idx,
    output logic       done
);

    // Only the three older dibits need storage; the 4th comes straight in.
    logic [5:0] sr;

    assign byte_data = {dibit, sr};
    assign done      = shift_en & ~clear & (dibit_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= 6'd0;
            dibit_idx <= 2'd0;
        end else if (clear) begin
            dibit_idx <= 2'd0;
        end else if (shift_en) begin
            sr        <= {dibit, sr[5:2]};
            dibit_idx <= dibit_idx + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rmii_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : rmii_rx_framer
// Description : RMII receive framer. Registers CRS_DV/RXD/RX_ER, locks onto
//               preamble + SFD, assembles bytes and emits them through a
//               one-byte hold register so the last byte carries eof/err.
//               Optional macro ETH_RX_STATS_EN adds frame and error counters.
// Ports       : clk, rst_n                        - 50 MHz clock, async reset
//               rmii_crs_dv, rmii_rxd, rmii_rx_er - RMII receive pins
//               rx_data, rx_valid                 - byte stream strobe
//               rx_sof, rx_eof, rx_err            - qualifiers (with rx_valid)
//               frame_cnt, err_cnt                - ETH_RX_STATS_EN only
// Revision    : 1.0 - initial release
// ============================================================================
module rmii_rx_framer
    import eth_types_pkg::*;
#(
    parameter int MIN_PREAMBLE    = 4,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rmii_crs_dv,
    input  logic [1:0]  rmii_rxd,
    input  logic        rmii_rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err
`ifdef ETH_RX_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [4:0]  MIN_PRE   = 5'(MIN_PREAMBLE);
    localparam logic [10:0] MAX_BYTES = 11'(MAX_FRAME_BYTES);

    logic          crs_q;
    logic [1:0]    rxd_q;
    logic          er_q;
    logic          prev_low;
    rmii_rx_states state;
    logic [4:0]    pre_cnt;
    logic [1:0]    pend_dibit;
    logic          pend_valid;
    logic [7:0]    held;
    logic          held_valid;
    logic          held_first;
    logic [10:0]   byte_cnt;
    logic          err_flag;
    logic          end_det;
    logic          asm_clear;
    logic          asm_shift;
    logic          asm_done;
    logic [1:0]    asm_dibit;
    logic [1:0]    asm_idx;
    logic [7:0]    asm_byte;
`ifdef ETH_RX_STATS_EN
    logic          abort_p;
`endif

    // Second consecutive low CRS_DV cycle.
    assign end_det   = ~crs_q & prev_low;
    assign asm_clear = (state != DATA);

    // A dibit seen with CRS_DV low may be the first of the two end cycles,
    // so it is parked one cycle; it only enters the assembler once the
    // following cycle proves the frame continues (nibble-rate toggling).
    always_comb begin
        asm_shift = 1'b0;
        asm_dibit = rxd_q;
        if (state == DATA && !end_det) begin
            if (pend_valid) begin
                asm_shift = 1'b1;
                asm_dibit = pend_dibit;
            end else if (crs_q) begin
                asm_shift = 1'b1;
            end
        end
    end

    rmii_byte_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .dibit     (asm_dibit),
        .byte_data (asm_byte),
        .dibit_idx (asm_idx),
        .done      (asm_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crs_q      <= 1'b0;
            rxd_q      <= 2'd0;
            er_q       <= 1'b0;
            prev_low   <= 1'b0;
            state      <= DRAIN;
            pre_cnt    <= 5'd0;
            pend_dibit <= 2'd0;
            pend_valid <= 1'b0;
            held       <= 8'd0;
            held_valid <= 1'b0;
            held_first <= 1'b0;
            byte_cnt   <= 11'd0;
            err_flag   <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            rx_eof     <= 1'b0;
            rx_err     <= 1'b0;
`ifdef ETH_RX_STATS_EN
            abort_p    <= 1'b0;
`endif
        end else begin
            crs_q    <= rmii_crs_dv;
            rxd_q    <= rmii_rxd;
            er_q     <= rmii_rx_er;
            prev_low <= ~crs_q;
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_err   <= 1'b0;
`ifdef ETH_RX_STATS_EN
            abort_p  <= 1'b0;
`endif
            case (state)
                DRAIN: begin
                    if (end_det) state <= IDLE;
                end
                IDLE: begin
                    if (crs_q && rxd_q == PREAMBLE_DIBIT) begin
                        state   <= PREAMBLE;
                        pre_cnt <= 5'd1;
                    end
                end
                PREAMBLE: begin
                    if (end_det) begin
                        state <= IDLE;
                    end else if (crs_q) begin
                        if (rxd_q == PREAMBLE_DIBIT) begin
                            if (pre_cnt != 5'd31) pre_cnt <= pre_cnt + 5'd1;
                        end else if (rxd_q == SFD_DIBIT && pre_cnt >= MIN_PRE) begin
                            state      <= DATA;
                            byte_cnt   <= 11'd0;
                            err_flag   <= 1'b0;
                            held_valid <= 1'b0;
                            pend_valid <= 1'b0;
                        end else begin
                            state <= DRAIN;
`ifdef ETH_RX_STATS_EN
                            abort_p <= 1'b1;
`endif
                        end
                    end
                end
                DATA: begin
                    if (end_det) begin
                        // The parked first-low dibit is dropped; any dibits
                        // left in the assembler mean the frame dribbled.
                        state      <= IDLE;
                        pend_valid <= 1'b0;
                        held_valid <= 1'b0;
                        if (held_valid) begin
                            rx_valid <= 1'b1;
                            rx_data  <= held;
                            rx_sof   <= held_first;
                            rx_eof   <= 1'b1;
                            rx_err   <= err_flag | er_q | (asm_idx != 2'd0);
                        end
                    end else begin
                        if (er_q) err_flag <= 1'b1;
                        if (!crs_q) begin
                            pend_dibit <= rxd_q;
                            pend_valid <= 1'b1;
                        end else if (pend_valid) begin
                            pend_dibit <= rxd_q;
                        end
                        if (asm_done) begin
                            if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
                            if (byte_cnt == MAX_BYTES) begin
                                // Byte MAX+1 completed: truncate the frame.
                                state      <= DRAIN;
                                held_valid <= 1'b0;
                                rx_valid   <= held_valid;
                                rx_data    <= held;
                                rx_sof     <= held_valid & held_first;
                                rx_eof     <= held_valid;
                                rx_err     <= held_valid;
                            end else begin
                                if (held_valid) begin
                                    rx_valid <= 1'b1;
                                    rx_data  <= held;
                                    rx_sof   <= held_first;
                                end
                                held       <= asm_byte;
                                held_valid <= 1'b1;
                                held_first <= (byte_cnt == 11'd0);
                            end
                        end
                    end
                end
                default: state <= DRAIN;
            endcase
        end
    end

`ifdef ETH_RX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
            err_cnt   <= 16'd0;
        end else begin
            if (rx_valid && rx_eof) frame_cnt <= frame_cnt + 16'd1;
            if ((rx_valid && rx_eof && rx_err) || abort_p) err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rmii_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rmii_rx_framer
// Description : Scoreboard bench for rmii_rx_framer. Two instances share one
//               RMII stimulus: the default build (MAX_FRAME_BYTES=1522) and a
//               truncating build (MAX_FRAME_BYTES=16). Expected bytes are
//               queued per instance as frames are driven and popped on
//               every rx_valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rmii_rx_framer;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       crs = 1'b0;
    logic [1:0] rxd = 2'b00;
    logic       er = 1'b0;

    logic [7:0] a_data, b_data;
    logic       a_valid, a_sof, a_eof, a_err;
    logic       b_valid, b_sof, b_eof, b_err;
`ifdef ETH_RX_STATS_EN
    logic [15:0] a_fcnt, a_ecnt, b_fcnt, b_ecnt;
`endif

    exp_t       exp_a[$];
    exp_t       exp_b[$];
    logic [7:0] fr[$];
    int         n_checks = 0;
    int         n_fail = 0;

    always #10 clk = ~clk;

    rmii_rx_framer #(.MIN_PREAMBLE(4), .MAX_FRAME_BYTES(1522)) dut (
        .clk(clk), .rst_n(rst_n), .rmii_crs_dv(crs), .rmii_rxd(rxd), .rmii_rx_er(er),
        .rx_data(a_data), .rx_valid(a_valid), .rx_sof(a_sof), .rx_eof(a_eof), .rx_err(a_err)
`ifdef ETH_RX_STATS_EN
        , .frame_cnt(a_fcnt), .err_cnt(a_ecnt)
`endif
    );

    rmii_rx_framer #(.MIN_PREAMBLE(4), .MAX_FRAME_BYTES(16)) dut_small (
        .clk(clk), .rst_n(rst_n), .rmii_crs_dv(crs), .rmii_rxd(rxd), .rmii_rx_er(er),
        .rx_data(b_data), .rx_valid(b_valid), .rx_sof(b_sof), .rx_eof(b_eof), .rx_err(b_err)
`ifdef ETH_RX_STATS_EN
        , .frame_cnt(b_fcnt), .err_cnt(b_ecnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic score(input int sel, input logic v, input logic [7:0] d,
                         input logic s, input logic e, input logic r);
        string nm;
        exp_t  x;
        bit    have;
        nm = (sel == 0) ? "a" : "b";
        x  = '0;
        if (!rst_n) begin
            check_eq($sformatf("rst_valid_%s", nm), {31'd0, v}, 32'd0);
            check_eq($sformatf("rst_data_%s", nm), {24'd0, d}, 32'd0);
            check_eq($sformatf("rst_flags_%s", nm), {29'd0, s, e, r}, 32'd0);
        end else if (v) begin
            if (sel == 0) begin
                have = (exp_a.size() != 0);
                if (have) x = exp_a.pop_front();
            end else begin
                have = (exp_b.size() != 0);
                if (have) x = exp_b.pop_front();
            end
            check_eq($sformatf("strobe_expected_%s", nm), {31'd0, have}, 32'd1);
            if (have) begin
                check_eq($sformatf("data_%s", nm), {24'd0, d}, {24'd0, x.d});
                check_eq($sformatf("sof_eof_err_%s", nm), {29'd0, s, e, r},
                         {29'd0, x.sof, x.eof, x.err});
            end
        end else begin
            check_eq($sformatf("idle_flags_%s", nm), {29'd0, s, e, r}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        score(0, a_valid, a_data, a_sof, a_eof, a_err);
        score(1, b_valid, b_data, b_sof, b_eof, b_err);
    end

    // Reference model: frames longer than maxb are cut to maxb bytes with
    // eof+err on the last one kept.
    task automatic expect_frame(input int maxb, input bit bad, input int sel);
        int n;
        int m;
        exp_t x;
        n = fr.size();
        m = (n > maxb) ? maxb : n;
        for (int i = 0; i < m; i++) begin
            x.d   = fr[i];
            x.sof = (i == 0);
            x.eof = (i == m - 1);
            x.err = (i == m - 1) && (bad || n > maxb);
            if (sel == 0) exp_a.push_back(x); else exp_b.push_back(x);
        end
    endtask

    task automatic expect_both(input bit bad);
        expect_frame(1522, bad, 0);
        expect_frame(16, bad, 1);
    endtask

    task automatic drive(input logic c, input logic [1:0] d, input logic e);
        @(posedge clk);
        #1;
        crs = c;
        rxd = d;
        er  = e;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00, 1'b0);
    endtask

    // npre preamble dibits, SFD, fr[] LSB-first, extra dribble dibits, then
    // two low cycles carrying non-zero dibits that must be discarded.
    task automatic send_frame(input int npre, input int er_dib, input int extra,
                              input int rst_on, input int rst_off);
        int k;
        logic [7:0] b;
        k = 0;
        for (int i = 0; i < npre; i++) drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < fr.size(); i++) begin
            b = fr[i];
            for (int j = 0; j < 4; j++) begin
                drive(1'b1, b[2*j +: 2], k == er_dib);
                if (k == rst_on) rst_n = 1'b0;
                if (k == rst_off) rst_n = 1'b1;
                k++;
            end
        end
        for (int i = 0; i < extra; i++) drive(1'b1, 2'b10, 1'b0);
        drive(1'b0, 2'b11, 1'b0);
        drive(1'b0, 2'b11, 1'b0);
        idle(4);
    endtask

    task automatic rand_frame(input int n);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(4);

        // Long preamble, bytes 0x01..0x40; small instance truncates at 16.
        fr.delete();
        for (int i = 1; i <= 64; i++) fr.push_back(8'(i));
        expect_both(1'b0);
        send_frame(31, -1, 0, -1, -1);

        // Preamble one short of the minimum: nothing emitted.
        rand_frame(8);
        send_frame(3, -1, 0, -1, -1);
        // Exactly the minimum preamble is accepted.
        rand_frame(5);
        expect_both(1'b0);
        send_frame(4, -1, 0, -1, -1);

        // Single byte with RX_ER on its 2nd dibit.
        fr = {8'hA5};
        expect_both(1'b1);
        send_frame(8, 1, 0, -1, -1);

        // Ten bytes plus two dribble dibits.
        rand_frame(10);
        expect_both(1'b1);
        send_frame(8, -1, 2, -1, -1);

        // Twenty bytes: clean on the big instance, truncated on the small.
        rand_frame(20);
        expect_both(1'b0);
        send_frame(8, -1, 0, -1, -1);
        rand_frame(6);
        expect_both(1'b0);
        send_frame(8, -1, 0, -1, -1);

        // Reset during byte 5: only bytes 1..3 were already emitted.
        rand_frame(12);
        for (int i = 0; i < 3; i++) begin
            exp_t x;
            x.d = fr[i]; x.sof = (i == 0); x.eof = 1'b0; x.err = 1'b0;
            exp_a.push_back(x);
            exp_b.push_back(x);
        end
        send_frame(8, -1, 0, 18, 22);
        rand_frame(7);
        expect_both(1'b0);
        send_frame(8, -1, 0, -1, -1);

        idle(10);
        check_eq("leftover_expected_a", exp_a.size(), 32'd0);
        check_eq("leftover_expected_b", exp_b.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t reached, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
